lieat_ifu_bpu: RTL and testbench

- Fetch-side branch predictor; the receiving end of the EXU BJP callback interface (callback_en/index/result/flush/truepc).
- Holds a 32-entry table of 2-bit saturating counters, indexed by pc[6:2].
- Gives a registered taken/not-taken prediction and next PC for conditional branches at fetch.
- Trains on BJP resolution; turns a callback flush into a registered redirect to the IFU.

---
 rtl/lieat_ifu_bpu_pkg.sv | 17 +
 rtl/lieat_bpu_satcnt.sv | 19 +
 rtl/lieat_ifu_bpu.sv | 123 ++++++++++++
 tb/tb_lieat_ifu_bpu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lieat_ifu_bpu_pkg.sv
// Shared constants and counter encodings for the fetch-side branch predictor.
// Optional gshare indexing is enabled by defining LIEAT_BPU_GSHARE_EN (undefined by default).
package lieat_ifu_bpu_pkg;

    localparam int BHT_IDX_W = 5;
    localparam int BHT_ENT   = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [1:0] CNT_RST = WNT;

endpackage

// File: rtl/lieat_bpu_satcnt.sv
// 2-bit saturating counter next-state function; purely combinational.
module lieat_bpu_satcnt
    import lieat_ifu_bpu_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        if (taken) begin
            if (cnt != ST) cnt_nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/lieat_ifu_bpu.sv
// Fetch-side BHT predictor: registered prediction, BJP-callback training and flush redirect.
// Define LIEAT_BPU_GSHARE_EN to XOR a 5-bit global history into both table indices.
module lieat_ifu_bpu
    import lieat_ifu_bpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ifu_req_valid,
    input  logic [XLEN-1:0]      ifu_req_pc,
    input  logic [XLEN-1:0]      ifu_req_imm,
    input  logic                 ifu_req_bxx,
    input  logic                 ifu_req_rv32,
    output logic                 bpu_prdt_valid,
    output logic                 bpu_prdt_taken,
    output logic [XLEN-1:0]      bpu_prdt_pc,
    input  logic                 callback_en,
    input  logic [BHT_IDX_W-1:0] callback_index,
    input  logic                 callback_result,
    input  logic                 callback_flush,
    input  logic [XLEN-1:0]      callback_truepc,
    output logic                 bpu_redirect_valid,
    output logic [XLEN-1:0]      bpu_redirect_pc
);

    logic [1:0]           cnt_q [BHT_ENT];
    logic                 upd_vld;
    logic                 upd_res;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BHT_IDX_W-1:0] lk_idx;
    logic [BHT_IDX_W-1:0] cb_idx;

`ifdef LIEAT_BPU_GSHARE_EN
    logic [BHT_IDX_W-1:0] ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ghr <= '0;
        else if (callback_en) ghr <= {ghr[BHT_IDX_W-2:0], callback_result};
    end

    // Update index uses the pre-shift history, matching the lookup that made the prediction.
    assign lk_idx = ifu_req_pc[BHT_IDX_W+1:2] ^ ghr;
    assign cb_idx = callback_index ^ ghr;
`else
    assign lk_idx = ifu_req_pc[BHT_IDX_W+1:2];
    assign cb_idx = callback_index;
`endif

    logic [1:0] upd_cur;
    logic [1:0] upd_nxt;
    logic [1:0] lk_raw;
    logic [1:0] lk_byp;
    logic [1:0] lk_cnt;

    assign upd_cur = cnt_q[upd_idx];
    assign lk_raw  = cnt_q[lk_idx];

    lieat_bpu_satcnt u_upd_cnt (
        .cnt     (upd_cur),
        .taken   (upd_res),
        .cnt_nxt (upd_nxt)
    );

    lieat_bpu_satcnt u_byp_cnt (
        .cnt     (lk_raw),
        .taken   (upd_res),
        .cnt_nxt (lk_byp)
    );

    // A pending update to the looked-up entry is forwarded so training is visible from t+1.
    assign lk_cnt = (upd_vld && (upd_idx == lk_idx)) ? lk_byp : lk_raw;

    logic            prdt_taken_d;
    logic [XLEN-1:0] prdt_pc_d;
    logic            flush_hit;

    assign prdt_taken_d = ifu_req_bxx & lk_cnt[1];
    assign prdt_pc_d    = prdt_taken_d ? (ifu_req_pc + ifu_req_imm)
                                       : (ifu_req_pc + (ifu_req_rv32 ? XLEN'(4) : XLEN'(2)));
    assign flush_hit    = callback_en & callback_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_vld <= 1'b0;
            upd_idx <= '0;
            upd_res <= 1'b0;
        end else begin
            upd_vld <= callback_en;
            if (callback_en) begin
                upd_idx <= cb_idx;
                upd_res <= callback_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENT; i++) cnt_q[i] <= CNT_RST;
        end else if (upd_vld) begin
            cnt_q[upd_idx] <= upd_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpu_prdt_valid     <= 1'b0;
            bpu_prdt_taken     <= 1'b0;
            bpu_prdt_pc        <= '0;
            bpu_redirect_valid <= 1'b0;
            bpu_redirect_pc    <= '0;
        end else begin
            bpu_prdt_valid     <= ifu_req_valid & ~flush_hit;
            bpu_redirect_valid <= flush_hit;
            if (ifu_req_valid) begin
                bpu_prdt_taken <= prdt_taken_d;
                bpu_prdt_pc    <= prdt_pc_d;
            end
            if (flush_hit) bpu_redirect_pc <= callback_truepc;
        end
    end

endmodule

// File: tb/tb_lieat_ifu_bpu.sv
// Directed bench for lieat_ifu_bpu: lookups, training, bypass, saturation, redirect, mid-run reset.
module tb_lieat_ifu_bpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_pc;
    logic [31:0] ifu_req_imm;
    logic        ifu_req_bxx;
    logic        ifu_req_rv32;
    logic        bpu_prdt_valid;
    logic        bpu_prdt_taken;
    logic [31:0] bpu_prdt_pc;
    logic        callback_en;
    logic [4:0]  callback_index;
    logic        callback_result;
    logic        callback_flush;
    logic [31:0] callback_truepc;
    logic        bpu_redirect_valid;
    logic [31:0] bpu_redirect_pc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lieat_ifu_bpu dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifu_req_valid      (ifu_req_valid),
        .ifu_req_pc         (ifu_req_pc),
        .ifu_req_imm        (ifu_req_imm),
        .ifu_req_bxx        (ifu_req_bxx),
        .ifu_req_rv32       (ifu_req_rv32),
        .bpu_prdt_valid     (bpu_prdt_valid),
        .bpu_prdt_taken     (bpu_prdt_taken),
        .bpu_prdt_pc        (bpu_prdt_pc),
        .callback_en        (callback_en),
        .callback_index     (callback_index),
        .callback_result    (callback_result),
        .callback_flush     (callback_flush),
        .callback_truepc    (callback_truepc),
        .bpu_redirect_valid (bpu_redirect_valid),
        .bpu_redirect_pc    (bpu_redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and checks live 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifu_req_valid   = 1'b0;
        ifu_req_pc      = '0;
        ifu_req_imm     = '0;
        ifu_req_bxx     = 1'b0;
        ifu_req_rv32    = 1'b0;
        callback_en     = 1'b0;
        callback_index  = '0;
        callback_result = 1'b0;
        callback_flush  = 1'b0;
        callback_truepc = '0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] imm, input logic bxx, input logic rv32);
        ifu_req_valid = 1'b1;
        ifu_req_pc    = pc;
        ifu_req_imm   = imm;
        ifu_req_bxx   = bxx;
        ifu_req_rv32  = rv32;
    endtask

    task automatic cb(input logic [4:0] idx, input logic res, input logic flush, input logic [31:0] tpc);
        callback_en     = 1'b1;
        callback_index  = idx;
        callback_result = res;
        callback_flush  = flush;
        callback_truepc = tpc;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_prdt_valid", 32'(bpu_prdt_valid), 32'd0);
        chk("rst_prdt_taken", 32'(bpu_prdt_taken), 32'd0);
        chk("rst_prdt_pc", bpu_prdt_pc, 32'h0);
        chk("rst_redir_valid", 32'(bpu_redirect_valid), 32'd0);
        chk("rst_redir_pc", bpu_redirect_pc, 32'h0);
        rst_n = 1'b1;
        step();

        // Fresh table is weakly not-taken.
        lookup(32'h100, 32'h40, 1'b1, 1'b1);
        step();
        chk("t1_valid", 32'(bpu_prdt_valid), 32'd1);
        chk("t1_taken", 32'(bpu_prdt_taken), 32'd0);
        chk("t1_pc", bpu_prdt_pc, 32'h104);
        idle();
        step();
        chk("idle_valid", 32'(bpu_prdt_valid), 32'd0);
        chk("idle_hold_pc", bpu_prdt_pc, 32'h104);

        // Back-to-back taken on idx 0: 01->10->11, second one via bypass.
        cb(5'd0, 1'b1, 1'b0, 32'h0);
        step();
        step();
        idle();
        lookup(32'h100, 32'h40, 1'b1, 1'b1);
        step();
        chk("b2b_valid", 32'(bpu_prdt_valid), 32'd1);
        chk("b2b_taken", 32'(bpu_prdt_taken), 32'd1);
        chk("b2b_pc", bpu_prdt_pc, 32'h140);

        // Four not-taken with a lookup each cycle: sees 11,10,01,00 then 00.
        cb(5'd0, 1'b0, 1'b0, 32'h0);
        lookup(32'h100, 32'h40, 1'b1, 1'b1);
        step(); chk("dec_lk1", 32'(bpu_prdt_taken), 32'd1);
        step(); chk("dec_lk2", 32'(bpu_prdt_taken), 32'd1);
        step(); chk("dec_lk3", 32'(bpu_prdt_taken), 32'd0);
        step(); chk("dec_lk4", 32'(bpu_prdt_taken), 32'd0);
        callback_en = 1'b0;
        step(); chk("dec_lk5", 32'(bpu_prdt_taken), 32'd0);
        chk("dec_pc", bpu_prdt_pc, 32'h104);
        // From saturated 00 one taken gives 01 (still NT), a second gives 10.
        idle();
        cb(5'd0, 1'b1, 1'b0, 32'h0);
        step();
        idle();
        lookup(32'h100, 32'h40, 1'b1, 1'b1);
        step(); chk("sat_lo_taken", 32'(bpu_prdt_taken), 32'd0);
        idle();
        cb(5'd0, 1'b1, 1'b0, 32'h0);
        step();
        idle();
        lookup(32'h100, 32'h40, 1'b1, 1'b1);
        step(); chk("inc_taken", 32'(bpu_prdt_taken), 32'd1);

        // Flush kills the simultaneous prediction and redirects for one cycle.
        idle();
        cb(5'd5, 1'b0, 1'b1, 32'h2000);
        lookup(32'h300, 32'h40, 1'b0, 1'b1);
        step();
        chk("fl_redir_valid", 32'(bpu_redirect_valid), 32'd1);
        chk("fl_redir_pc", bpu_redirect_pc, 32'h2000);
        chk("fl_prdt_valid", 32'(bpu_prdt_valid), 32'd0);
        idle();
        step();
        chk("fl_redir_drop", 32'(bpu_redirect_valid), 32'd0);

        // Flush without callback_en is ignored; bxx=0 never predicts taken.
        callback_flush  = 1'b1;
        callback_truepc = 32'h3000;
        lookup(32'h300, 32'h40, 1'b0, 1'b1);
        step();
        chk("nofl_redir", 32'(bpu_redirect_valid), 32'd0);
        chk("nofl_valid", 32'(bpu_prdt_valid), 32'd1);
        chk("nofl_taken", 32'(bpu_prdt_taken), 32'd0);
        chk("nofl_pc", bpu_prdt_pc, 32'h304);

        // Same-cycle callback is invisible; next-cycle lookup sees it.
        idle();
        cb(5'd3, 1'b1, 1'b0, 32'h0);
        lookup(32'h0C, 32'h10, 1'b1, 1'b1);
        step();
        chk("same_taken", 32'(bpu_prdt_taken), 32'd0);
        chk("same_pc", bpu_prdt_pc, 32'h10);
        callback_en = 1'b0;
        step();
        chk("next_taken", 32'(bpu_prdt_taken), 32'd1);
        chk("next_pc", bpu_prdt_pc, 32'h1C);

        // Reset between capture and table write drops the pending update.
        idle();
        cb(5'd7, 1'b1, 1'b0, 32'h0);
        step();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bpu_prdt_valid), 32'd0);
        chk("mid_rst_pc", bpu_prdt_pc, 32'h0);
        step();
        lookup(32'h200, 32'h80, 1'b1, 1'b0);
        step();
        chk("rv16_taken", 32'(bpu_prdt_taken), 32'd0);
        chk("rv16_pc", bpu_prdt_pc, 32'h202);
        lookup(32'h1C, 32'h20, 1'b1, 1'b1);
        step();
        chk("drop_upd_taken", 32'(bpu_prdt_taken), 32'd0);
        chk("drop_upd_pc", bpu_prdt_pc, 32'h20);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
